// File: rtl/noc_pkg.sv
// noc_pkg: NoC opcodes, header field layout and header packer.
// Shared by the NoC encoder and decoder.
package noc_pkg;

  localparam logic [2:0] OP_MDATA  = 3'd2;
  localparam logic [2:0] OP_QM     = 3'd3;
  localparam logic [2:0] OP_MPUT   = 3'd4;
  localparam logic [2:0] OP_MGET   = 3'd5;
  localparam logic [2:0] OP_MLOAD  = 3'd6;
  localparam logic [2:0] OP_MSTORE = 3'd7;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_OFF_LSB  = 6;
  localparam int HDR_SRC_LSB  = 18;
  localparam int HDR_CODE_LSB = 25;
  localparam int HDR_HL_BIT   = 28;

  function automatic logic [31:0] hdr_pack(
    input logic        hl,
    input logic [2:0]  code,
    input logic [5:0]  src,
    input logic [11:0] off,
    input logic [5:0]  dest
  );
    logic [31:0] h;
    h = '0;
    h[HDR_HL_BIT]          = hl;
    h[HDR_CODE_LSB +: 3]   = code;
    h[HDR_SRC_LSB +: 6]    = src;
    h[HDR_OFF_LSB +: 12]   = off;
    h[HDR_DEST_LSB +: 6]   = dest;
    return h;
  endfunction

  function automatic logic op_ok(input logic [2:0] code);
    return (code == OP_QM) || (code == OP_MPUT) ||
           (code == OP_MGET) || (code == OP_MLOAD) ||
           (code == OP_MSTORE);
  endfunction

  function automatic logic op_read(input logic [2:0] code);
    return (code == OP_MGET) || (code == OP_MLOAD);
  endfunction

  function automatic logic op_waits(input logic [2:0] code);
    return (code == OP_MLOAD) || (code == OP_MSTORE);
  endfunction

  function automatic logic op_wlen(input logic [2:0] code);
    return (code == OP_MPUT) || (code == OP_MSTORE);
  endfunction

endpackage

// File: rtl/noc_hdr_pack.sv
// noc_hdr_pack: builds header word 1 from registered command fields.
// Long headers carry the burst length inside the offset field.
module noc_hdr_pack
  import noc_pkg::*;
(
  input  logic        hl,
  input  logic [2:0]  code,
  input  logic [5:0]  src_id,
  input  logic [5:0]  dest,
  input  logic [11:0] offset,
  input  logic [3:0]  len,
  output logic [31:0] hdr
);

  logic [11:0] off_sel;

  // Writes put len in header[11:8], reads in header[15:12].
  always_comb begin
    off_sel = offset;
    if (hl) begin
      if (op_wlen(code)) off_sel = {6'h0, len, 2'b00};
      else               off_sel = {2'h0, len, 6'h0};
    end
  end

  assign hdr = hdr_pack(hl, code, src_id, off_sel, dest);

endmodule

// File: rtl/noc_encoder.sv
// noc_encoder: turns local commands into NoC packets.
// Header(s), then payload or read request; waits for MLOAD/MSTORE replies.
module noc_encoder
  import noc_pkg::*;
#(
  parameter int XY_SZ        = 3,
  parameter int MAX_LEN_LOG2 = 8
) (
  input  logic                 clk_ctrl,
  input  logic                 clk_ctrl_rst,
  input  logic [XY_SZ*2-1:0]   HsrcId,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_code,
  input  logic                 cmd_long,
  input  logic [5:0]           cmd_dest,
  input  logic [11:0]          cmd_offset,
  input  logic [31:0]          cmd_addr,
  input  logic [3:0]           cmd_len_log2,
  input  logic [31:0]          cmd_ret,
  input  logic                 wr_TVALID,
  input  logic [31:0]          wr_TDATA,
  output logic                 wr_TREADY,
  output logic                 stream_out_TVALID,
  output logic [31:0]          stream_out_TDATA,
  output logic [3:0]           stream_out_TKEEP,
  output logic                 stream_out_TLAST,
  input  logic                 stream_out_TREADY,
  input  logic                 unblock,
  output logic                 blocked,
  output logic                 cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_HDR2,
    S_PAYLOAD,
    S_REQ,
    S_WAIT_RESP
  } enc_state_e;

  enc_state_e  state_q, state_d;
  logic        hl_q;
  logic [2:0]  code_q;
  logic [5:0]  dest_q;
  logic [11:0] off_q;
  logic [31:0] addr_q;
  logic [31:0] ret_q;
  logic [3:0]  len_q;
  logic [8:0]  cnt_q;
  logic        err_q;

  logic        accept;
  logic        bad;
  logic        beat;
  logic [5:0]  src_id;
  logic [31:0] hdr_w;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        wr_rdy;

  assign src_id = 6'(HsrcId);
  assign accept = cmd_valid && cmd_ready;
  assign bad    = !op_ok(cmd_code) ||
                  (int'(cmd_len_log2) > MAX_LEN_LOG2);
  assign beat   = stream_out_TVALID && stream_out_TREADY;

  noc_hdr_pack u_hdr (
    .hl     (hl_q),
    .code   (code_q),
    .src_id (src_id),
    .dest   (dest_q),
    .offset (off_q),
    .len    (len_q),
    .hdr    (hdr_w)
  );

  // State, captured command and payload beat counter.
  always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
    if (clk_ctrl_rst) begin
      state_q <= S_IDLE;
      hl_q    <= 1'b0;
      code_q  <= '0;
      dest_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      ret_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && bad;
      if (accept && !bad) begin
        hl_q   <= cmd_long && (cmd_code != OP_QM);
        code_q <= cmd_code;
        dest_q <= cmd_dest;
        off_q  <= cmd_offset;
        addr_q <= cmd_addr;
        ret_q  <= cmd_ret;
        len_q  <= cmd_len_log2;
        cnt_q  <= 9'((32'd1 << cmd_len_log2) - 32'd1);
      end else if (state_q == S_PAYLOAD && beat &&
                   cnt_q != 9'd0) begin
        cnt_q <= cnt_q - 9'd1;
      end
    end
  end

  // Next state and stream outputs per state.
  always_comb begin
    state_d = state_q;
    tvalid  = 1'b0;
    tdata   = '0;
    tlast   = 1'b0;
    wr_rdy  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !bad) state_d = S_HDR1;
      end
      S_HDR1: begin
        tvalid = 1'b1;
        tdata  = hdr_w;
        if (stream_out_TREADY) begin
          if (hl_q)                 state_d = S_HDR2;
          else if (op_read(code_q)) state_d = S_REQ;
          else                      state_d = S_PAYLOAD;
        end
      end
      S_HDR2: begin
        tvalid = 1'b1;
        tdata  = addr_q;
        if (stream_out_TREADY) begin
          if (op_read(code_q)) state_d = S_REQ;
          else                 state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        tvalid = wr_TVALID;
        tdata  = wr_TDATA;
        wr_rdy = stream_out_TREADY;
        tlast  = (cnt_q == 9'd0);
        if (wr_TVALID && stream_out_TREADY &&
            cnt_q == 9'd0) begin
          state_d = op_waits(code_q) ? S_WAIT_RESP : S_IDLE;
        end
      end
      S_REQ: begin
        tvalid = 1'b1;
        tdata  = ret_q;
        tlast  = 1'b1;
        if (stream_out_TREADY) begin
          state_d = op_waits(code_q) ? S_WAIT_RESP : S_IDLE;
        end
      end
      S_WAIT_RESP: begin
        if (unblock) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign blocked           = (state_q == S_WAIT_RESP);
  assign cmd_ready         = (state_q == S_IDLE) && !blocked &&
                             !clk_ctrl_rst;
  assign cmd_err           = err_q;
  assign stream_out_TVALID = tvalid;
  assign stream_out_TDATA  = tdata;
  assign stream_out_TLAST  = tlast;
  assign stream_out_TKEEP  = 4'hF;
  assign wr_TREADY         = wr_rdy;

endmodule

// File: tb/tb_noc_encoder.sv
// tb_noc_encoder: vector table, directed corner cases and random
// commands checked against a packet-level model of the encoder.
module tb_noc_encoder;

  localparam int         MAXL = 8;
  localparam logic [5:0] SRC  = 6'h12;

  logic        clk_ctrl     = 1'b0;
  logic        clk_ctrl_rst = 1'b1;
  logic [5:0]  HsrcId       = SRC;
  logic        cmd_valid    = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_code     = '0;
  logic        cmd_long     = 1'b0;
  logic [5:0]  cmd_dest     = '0;
  logic [11:0] cmd_offset   = '0;
  logic [31:0] cmd_addr     = '0;
  logic [3:0]  cmd_len_log2 = '0;
  logic [31:0] cmd_ret      = '0;
  logic        wr_TVALID    = 1'b0;
  logic [31:0] wr_TDATA;
  logic        wr_TREADY;
  logic        stream_out_TVALID;
  logic [31:0] stream_out_TDATA;
  logic [3:0]  stream_out_TKEEP;
  logic        stream_out_TLAST;
  logic        stream_out_TREADY = 1'b0;
  logic        unblock      = 1'b0;
  logic        blocked;
  logic        cmd_err;

  always #5 clk_ctrl = ~clk_ctrl;

  noc_encoder #(.XY_SZ(3), .MAX_LEN_LOG2(MAXL)) dut (
    .clk_ctrl          (clk_ctrl),
    .clk_ctrl_rst      (clk_ctrl_rst),
    .HsrcId            (HsrcId),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_code          (cmd_code),
    .cmd_long          (cmd_long),
    .cmd_dest          (cmd_dest),
    .cmd_offset        (cmd_offset),
    .cmd_addr          (cmd_addr),
    .cmd_len_log2      (cmd_len_log2),
    .cmd_ret           (cmd_ret),
    .wr_TVALID         (wr_TVALID),
    .wr_TDATA          (wr_TDATA),
    .wr_TREADY         (wr_TREADY),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .stream_out_TREADY (stream_out_TREADY),
    .unblock           (unblock),
    .blocked           (blocked),
    .cmd_err           (cmd_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } beat_t;

  typedef struct {
    int          code;
    int          lng;
    int          dest;
    int          off;
    logic [31:0] addr;
    int          len;
    logic [31:0] ret;
    logic [31:0] hdr;
  } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    src_idx  = 0;
  int    rdy_mode = 0;
  int    wv_mode  = 0;
  logic  wr_hs    = 1'b0;
  int    n_chk    = 0;
  int    n_fail   = 0;
  int    got_rd   = 0;
  int    mdl_idx  = 0;

  function automatic logic [31:0] pay_word(input int k);
    return 32'hA500_0000 + 32'(k) * 32'd7 + 32'd1;
  endfunction

  assign wr_TDATA = pay_word(src_idx);

  function automatic beat_t mk(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    b.keep = 4'hF;
    return b;
  endfunction

  // Records accepted output beats; drives TREADY and the payload source.
  always begin
    beat_t b;
    @(negedge clk_ctrl);
    wr_hs = wr_TVALID && wr_TREADY;
    if (stream_out_TVALID && stream_out_TREADY) begin
      b.data = stream_out_TDATA;
      b.last = stream_out_TLAST;
      b.keep = stream_out_TKEEP;
      got_q.push_back(b);
    end
    @(posedge clk_ctrl);
    #1;
    if (wr_hs) src_idx++;
    case (rdy_mode)
      0:       stream_out_TREADY = 1'b1;
      1:       stream_out_TREADY = ~stream_out_TREADY;
      default: stream_out_TREADY = 1'($urandom_range(0, 1));
    endcase
    if (wv_mode == 0) wr_TVALID = 1'b1;
    else if (!(wr_TVALID && !wr_hs))
      wr_TVALID = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ctrl);
    #2;
  endtask

  // Header word from the field layout, in plain arithmetic.
  function automatic logic [31:0] model_hdr(input int code, input int lng,
                                            input int dest, input int off,
                                            input int len);
    int hl, o;
    hl = (lng != 0 && code != 3) ? 1 : 0;
    if (hl == 0)                     o = off;
    else if (code == 4 || code == 7) o = len * 4;
    else                             o = len * 64;
    return 32'(hl * (1 << 28) + code * (1 << 25) +
               int'(SRC) * (1 << 18) + o * 64 + dest);
  endfunction

  task automatic issue(input int code, input int lng, input int dest,
                       input int off, input logic [31:0] addr,
                       input int len, input logic [31:0] ret);
    int n;
    cmd_code     = 3'(code);
    cmd_long     = 1'(lng);
    cmd_dest     = 6'(dest);
    cmd_offset   = 12'(off);
    cmd_addr     = addr;
    cmd_len_log2 = 4'(len);
    cmd_ret      = ret;
    cmd_valid    = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int code, input int lng, input int dest,
                         input int off, input logic [31:0] addr,
                         input int len, input logic [31:0] ret,
                         input logic [31:0] hdr_exp);
    bit          bad, hl, rd, stall;
    int          n, nb;
    logic [31:0] pd;
    logic        pl;
    bad = (code < 3) || (len > MAXL);
    hl  = (lng != 0) && (code != 3);
    rd  = (code == 5) || (code == 6);
    issue(code, lng, dest, off, addr, len, ret);
    if (bad) begin
      chk("err_pulse", 32'(cmd_err), 32'd1);
      chk("err_no_valid", 32'(stream_out_TVALID), 32'd0);
      tick();
      chk("err_clear", 32'(cmd_err), 32'd0);
      chk("err_no_valid2", 32'(stream_out_TVALID), 32'd0);
      chk("err_ready", 32'(cmd_ready), 32'd1);
      chk("err_no_beats", 32'(got_q.size() - got_rd), 32'd0);
      return;
    end
    chk("hdr_lat_valid", 32'(stream_out_TVALID), 32'd1);
    chk("hdr_lat_data", stream_out_TDATA, hdr_exp);
    exp_q.delete();
    exp_q.push_back(mk(model_hdr(code, lng, dest, off, len), 1'b0));
    if (hl) exp_q.push_back(mk(addr, 1'b0));
    if (rd) exp_q.push_back(mk(ret, 1'b1));
    else begin
      nb = 1 << len;
      for (int i = 0; i < nb; i++) begin
        exp_q.push_back(mk(pay_word(mdl_idx), 1'(i == nb - 1)));
        mdl_idx++;
      end
    end
    n = 0;
    while (got_q.size() - got_rd < exp_q.size() && n < 5000) begin
      stall = stream_out_TVALID && !stream_out_TREADY;
      pd    = stream_out_TDATA;
      pl    = stream_out_TLAST;
      tick();
      n++;
      if (stall) begin
        chk("stall_valid", 32'(stream_out_TVALID), 32'd1);
        chk("stall_data", stream_out_TDATA, pd);
        chk("stall_last", 32'(pl), 32'(stream_out_TLAST));
      end
    end
    chk("beat_count", 32'(got_q.size() - got_rd), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        chk("beat_data", got_q[got_rd].data, exp_q[i].data);
        chk("beat_last", 32'(got_q[got_rd].last), 32'(exp_q[i].last));
        chk("beat_keep", 32'(got_q[got_rd].keep), 32'hF);
        got_rd++;
      end
    end
    if (code == 6 || code == 7) begin
      chk("blocked_after", 32'(blocked), 32'd1);
      chk("ready_blocked", 32'(cmd_ready), 32'd0);
      tick();
      tick();
      chk("blocked_hold", 32'(blocked), 32'd1);
      unblock = 1'b1;
      tick();
      unblock = 1'b0;
      chk("unblocked", 32'(blocked), 32'd0);
      chk("ready_unblock", 32'(cmd_ready), 32'd1);
    end else begin
      chk("not_blocked", 32'(blocked), 32'd0);
      chk("idle_no_valid", 32'(stream_out_TVALID), 32'd0);
    end
  endtask

  vec_t tbl[9];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int code, lng, len, n;
    tbl[0] = '{4, 0, 9,    12'h010, 32'h0,         2, 32'h0,   32'h0848_0409};
    tbl[1] = '{5, 1, 5,    12'h000, 32'h0000_1000, 2, 32'hABC, 32'h1A48_2005};
    tbl[2] = '{7, 1, 6'h21, 12'hFFF, 32'hDEAD_0000, 3, 32'h0,  32'h1E48_0321};
    tbl[3] = '{3, 1, 6'h3F, 12'h123, 32'h1111_2222, 0, 32'h0,  32'h0648_48FF};
    tbl[4] = '{6, 0, 2,    12'hABC, 32'h0,         1, 32'h55,  32'h0C4A_AF02};
    tbl[5] = '{2, 0, 1,    12'h000, 32'h0,         1, 32'h0,   32'h0};
    tbl[6] = '{4, 0, 1,    12'h000, 32'h0,         9, 32'h0,   32'h0};
    tbl[7] = '{0, 1, 7,    12'h001, 32'h0,         0, 32'h0,   32'h0};
    tbl[8] = '{4, 1, 1,    12'h000, 32'h1234_5678, 8, 32'h0,   32'h1848_0801};

    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_tvalid", 32'(stream_out_TVALID), 32'd0);
    chk("rst_tlast", 32'(stream_out_TLAST), 32'd0);
    chk("rst_tdata", stream_out_TDATA, 32'd0);
    chk("rst_wr_tready", 32'(wr_TREADY), 32'd0);
    chk("rst_blocked", 32'(blocked), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    clk_ctrl_rst = 1'b0;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    mdl_idx = src_idx;

    foreach (tbl[i])
      run_cmd(tbl[i].code, tbl[i].lng, tbl[i].dest, tbl[i].off,
              tbl[i].addr, tbl[i].len, tbl[i].ret, tbl[i].hdr);

    rdy_mode = 1;
    run_cmd(7, 1, 3, 0, 32'hCAFE_0000, 2, 32'h0,
            model_hdr(7, 1, 3, 0, 2));
    rdy_mode = 0;

    tick();
    issue(4, 0, 3, 12'h040, 32'h0, 3, 32'h0);
    n = 0;
    while (got_q.size() - got_rd < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_beat2_valid", 32'(stream_out_TVALID), 32'd1);
    clk_ctrl_rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(stream_out_TVALID), 32'd0);
    chk("mid_rst_tlast", 32'(stream_out_TLAST), 32'd0);
    chk("mid_rst_tdata", stream_out_TDATA, 32'd0);
    chk("mid_rst_wr_tready", 32'(wr_TREADY), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    tick();
    clk_ctrl_rst = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rel_blocked", 32'(blocked), 32'd0);
    got_rd  = got_q.size();
    mdl_idx = src_idx;
    run_cmd(3, 0, 4, 12'h00F, 32'h0, 1, 32'h0,
            model_hdr(3, 0, 4, 12'h00F, 1));

    unblock = 1'b1;
    tick();
    unblock = 1'b0;
    chk("idle_unblock_blocked", 32'(blocked), 32'd0);
    chk("idle_unblock_ready", 32'(cmd_ready), 32'd1);
    run_cmd(6, 1, 8, 0, 32'h0000_2000, 3, 32'h0000_0777,
            model_hdr(6, 1, 8, 0, 3));

    rdy_mode = 2;
    wv_mode  = 1;
    for (int i = 0; i < 40; i++) begin
      int dest, off;
      logic [31:0] addr, ret;
      code = $urandom_range(0, 7);
      lng  = $urandom_range(0, 1);
      dest = $urandom_range(0, 63);
      off  = $urandom_range(0, 4095);
      addr = $urandom;
      ret  = $urandom;
      len  = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 9)
                                         : $urandom_range(0, 4);
      run_cmd(code, lng, dest, off, addr, len, ret,
              model_hdr(code, lng, dest, off, len));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
